// File: rtl/x_delay_line_ctrl.sv
// Delay-line TDC sequencer: launches edges, samples resolved taps, averages tap counts.
// Latency: p_avg * (1 + p_sync+1 + >=p_settle) cycles from i_start to o_valid.
// Backpressure: result held stable in OUT until i_ready; i_start ignored while busy.
module x_delay_line_ctrl #(
    parameter int p_cells    = 64,
    parameter int p_sync     = 4,
    parameter int p_avg_log2 = 2,
    parameter int p_settle   = 8
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_start,
    output logic                           o_busy,
    output logic                           o_launch,
    input  logic [p_cells-1:0]             i_q,
    output logic [$clog2(p_cells+1)-1:0]   o_data,
    output logic                           o_err,
    output logic                           o_valid,
    input  logic                           i_ready
);

    localparam int CW    = $clog2(p_cells + 1);
    localparam int AW    = CW + p_avg_log2;
    localparam int SW    = p_avg_log2 + 1;
    localparam int P_AVG = 1 << p_avg_log2;
    localparam int WW    = $clog2(p_sync + 1) + 1;
    localparam int SCW   = (p_settle > 256) ? $clog2(p_settle + 1) : 9;
    // Last SETTLE cycle index after which the chain is given up on.
    localparam int TMO   = 255;
    localparam int SMIN  = (p_settle > 0) ? p_settle - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WW-1:0]  wait_cnt;
    logic [SCW-1:0] settle_cnt;
    logic [SW-1:0]  samp_cnt;
    logic [AW-1:0]  acc;
    logic           err_flag;

    logic [CW-1:0]  run_cnt;
    logic           hole;
    logic           bubble;
    logic           saturated;
    logic           sample_bad;
    logic           q_nonzero;
    logic           settle_min;
    logic           settle_tmo;
    logic           settle_done;
    logic           all_taken;
    logic           capture;
    logic           settle_exit;
    logic           meas_start;
    logic           transfer;

    // Thermometer decode: length of the run of ones from tap 0, plus bubble detect.
    always_comb begin
        run_cnt = '0;
        hole    = 1'b0;
        bubble  = 1'b0;
        for (int i = 0; i < p_cells; i++) begin
            if (!i_q[i]) begin
                hole = 1'b1;
            end else if (hole) begin
                bubble = 1'b1;
            end else begin
                run_cnt = CW'(i + 1);
            end
        end
    end

    assign saturated   = &i_q;
    assign sample_bad  = bubble | saturated;
    assign q_nonzero   = |i_q;
    assign settle_min  = (settle_cnt >= SCW'(SMIN));
    assign settle_tmo  = (settle_cnt >= SCW'(TMO));
    // Leave SETTLE once the chain has drained, or give up when it never does.
    assign settle_done = settle_min & (~q_nonzero | settle_tmo);
    assign all_taken   = (samp_cnt >= SW'(P_AVG));
    assign meas_start  = (state == ST_IDLE) & i_start;
    assign transfer    = (state == ST_OUT) & i_ready;
    assign o_busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle strobes.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        settle_exit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == WW'(p_sync)) begin
                    capture   = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    settle_exit = 1'b1;
                    state_nxt   = all_taken ? ST_OUT : ST_LAUNCH;
                end
            end
            ST_OUT: begin
                if (i_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Launch edge: rises leaving LAUNCH, held through WAIT, dropped at the capture edge.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_launch <= 1'b0;
        end else begin
            o_launch <= (state == ST_LAUNCH) | ((state == ST_WAIT) & ~capture);
        end
    end

    // Counts edges since launch so the capture lands p_sync+1 edges after it.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wait_cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Counts cycles spent in SETTLE; bounded by the timeout so it cannot wrap.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            settle_cnt <= '0;
        end else if (capture) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // Per-measurement accumulator, sample count and sticky error flag.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            acc      <= '0;
            samp_cnt <= '0;
            err_flag <= 1'b0;
        end else if (meas_start) begin
            acc      <= '0;
            samp_cnt <= '0;
            err_flag <= 1'b0;
        end else if (capture) begin
            acc      <= acc + AW'(run_cnt);
            samp_cnt <= samp_cnt + 1'b1;
            err_flag <= err_flag | sample_bad;
        end else if (settle_exit) begin
            err_flag <= err_flag | q_nonzero;
        end
    end

    // Result registers: loaded entering OUT, held until the next result.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_data <= '0;
            o_err  <= 1'b0;
        end else if (settle_exit && all_taken) begin
            o_data <= acc[AW-1:p_avg_log2];
            o_err  <= err_flag | q_nonzero;
        end
    end

    // Valid rises with the result and falls on the edge after the transfer.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_valid <= 1'b0;
        end else if (settle_exit && all_taken) begin
            o_valid <= 1'b1;
        end else if (transfer) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Bench for x_delay_line_ctrl: tap-chain model driven off o_launch, results checked
// against tap counts computed from the programmed sample patterns.
// Runs directed cases from the test plan, then a randomized loop.
module tb_x_delay_line_ctrl;

    localparam int P_CELLS    = 8;
    localparam int P_SYNC     = 4;
    localparam int P_AVG_LOG2 = 2;
    localparam int P_SETTLE   = 8;
    localparam int P_AVG      = 1 << P_AVG_LOG2;
    localparam int CW         = $clog2(P_CELLS + 1);

    logic               clk   = 1'b0;
    logic               nrst  = 1'b0;
    logic               start = 1'b0;
    logic               ready = 1'b0;
    logic               busy;
    logic               launch;
    logic               err;
    logic               valid;
    logic [P_CELLS-1:0] q = '0;
    logic [CW-1:0]      data;

    int checks = 0;
    int errors = 0;

    // Sample programme for the current measurement.
    logic [P_CELLS-1:0] pat  [P_AVG];
    logic [P_CELLS-1:0] hval [P_AVG];
    int                 hold [P_AVG];

    // Tap model / launch monitor state.
    int   hi_len[$];
    int   lo_len[$];
    int   li     = 0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    logic busy_q   = 1'b0;
    logic launch_q = 1'b0;

    x_delay_line_ctrl #(
        .p_cells   (P_CELLS),
        .p_sync    (P_SYNC),
        .p_avg_log2(P_AVG_LOG2),
        .p_settle  (P_SETTLE)
    ) dut (
        .i_clk   (clk),
        .i_nrst  (nrst),
        .i_start (start),
        .o_busy  (busy),
        .o_launch(launch),
        .i_q     (q),
        .o_data  (data),
        .o_err   (err),
        .o_valid (valid),
        .i_ready (ready)
    );

    always #5 clk = ~clk;

    // Delay-line model: pattern resolves only in the cycle the capture should use,
    // complement elsewhere; after the launch falls the chain stays dirty for hold[] cycles.
    always @(negedge clk) begin
        if (busy && !busy_q) begin
            li = 0;
            lo_cnt = 0;
            hi_len.delete();
            lo_len.delete();
        end
        if (launch && !launch_q) begin
            if (li > 0) lo_len.push_back(lo_cnt);
            hi_cnt = 0;
        end
        if (!launch && launch_q) begin
            hi_len.push_back(hi_cnt);
            li = li + 1;
            lo_cnt = 0;
        end
        if (launch) hi_cnt = hi_cnt + 1;
        else        lo_cnt = lo_cnt + 1;

        if (launch && li < P_AVG) begin
            q = (hi_cnt == P_SYNC + 1) ? pat[li] : ~pat[li];
        end else if (!launch && li > 0 && li <= P_AVG && lo_cnt <= hold[li-1]) begin
            q = hval[li-1];
        end else begin
            q = '0;
        end
        busy_q   = busy;
        launch_q = launch;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int run_len(input logic [P_CELLS-1:0] p);
        int c = 0;
        while (c < P_CELLS && p[c]) c++;
        return c;
    endfunction

    function automatic bit is_bad(input logic [P_CELLS-1:0] p);
        int c = run_len(p);
        return (c == P_CELLS) || ((p >> c) != 0);
    endfunction

    // Low cycles between launches: SETTLE (min p_settle, until clean, max 256) + LAUNCH.
    function automatic int exp_gap(input int h);
        int g = (h + 1 > P_SETTLE) ? h + 1 : P_SETTLE;
        if (g > 256) g = 256;
        return g + 1;
    endfunction

    task automatic set_pats(input logic [P_CELLS-1:0] p0, input logic [P_CELLS-1:0] p1,
                            input logic [P_CELLS-1:0] p2, input logic [P_CELLS-1:0] p3);
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        for (int k = 0; k < P_AVG; k++) begin
            hold[k] = 0;
            hval[k] = 8'h3C;
        end
    endtask

    // One measurement: optional start, wait for result, check it, apply backpressure, drain.
    task automatic run_meas(input bit do_start, input int rdy_dly, input bit poke_start,
                            input bit hold_start);
        int  sum = 0;
        bit  e   = 0;
        int  n   = 0;
        int  exp_data;
        for (int k = 0; k < P_AVG; k++) begin
            sum += run_len(pat[k]);
            if (is_bad(pat[k])) e = 1;
            if (hold[k] >= 256) e = 1;
        end
        exp_data = sum >> P_AVG_LOG2;
        if (do_start) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        while (!valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", int'(valid), 1);
        if (!valid) return;
        check("data", int'(data), exp_data);
        check("err", int'(err), int'(e));
        check("launch_count", hi_len.size(), P_AVG);
        foreach (hi_len[i]) check("launch_width", hi_len[i], P_SYNC + 1);
        check("gap_count", lo_len.size(), P_AVG - 1);
        foreach (lo_len[i]) check("launch_gap", lo_len[i], exp_gap(hold[i]));
        for (int c = 0; c < rdy_dly; c++) begin
            if (poke_start) start = c[0];
            @(negedge clk);
            check("bp_valid", int'(valid), 1);
            check("bp_data", int'(data), exp_data);
            check("bp_launch", int'(launch), 0);
        end
        start = hold_start;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("valid_drop", int'(valid), 0);
        check("busy_drop", int'(busy), 0);
        check("data_hold", int'(data), exp_data);
    endtask

    initial begin
        bit   saw_valid;
        logic [P_CELLS-1:0] rp [P_AVG];
        set_pats(8'h07, 8'h07, 8'h07, 8'h07);

        // Reset values.
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_launch", int'(launch), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk); nrst = 1'b1;

        // Nominal: count 3 on every sample.
        run_meas(1, 0, 0, 0);

        // Reset in the middle of WAIT.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        check("pre_rst_launch", int'(launch), 1);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_launch", int'(launch), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_data", int'(data), 0);
        @(negedge clk); @(negedge clk); nrst = 1'b1;
        saw_valid = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (valid) saw_valid = 1;
        end
        check("no_partial_result", int'(saw_valid), 0);
        run_meas(1, 0, 0, 0);

        // Averaging and truncation.
        set_pats(8'h07, 8'h0F, 8'h0F, 8'h1F);
        run_meas(1, 0, 0, 0);
        set_pats(8'h07, 8'h07, 8'h07, 8'h0F);
        run_meas(1, 0, 0, 0);

        // Bubble and saturation.
        set_pats(8'h0B, 8'h03, 8'h03, 8'h03);
        run_meas(1, 0, 0, 0);
        set_pats(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_meas(1, 0, 0, 0);

        // Backpressure with ignored start pulses during OUT.
        set_pats(8'h01, 8'h3F, 8'h1F, 8'h7F);
        run_meas(1, 10, 1, 0);

        // Slow drain after the first launch.
        set_pats(8'h0F, 8'h0F, 8'h0F, 8'h0F);
        hold[0] = 20;
        run_meas(1, 0, 0, 0);

        // Stuck chain: every settle times out.
        set_pats(8'h01, 8'h01, 8'h01, 8'h01);
        for (int k = 0; k < P_AVG; k++) begin
            hold[k] = 300;
            hval[k] = 8'h01;
        end
        run_meas(1, 0, 0, 0);

        // Back-to-back with start held: one IDLE cycle then relaunch.
        set_pats(8'h03, 8'h07, 8'h0F, 8'h1F);
        run_meas(1, 2, 0, 1);
        @(negedge clk);
        check("relaunch_busy", int'(busy), 1);
        start = 1'b0;
        run_meas(0, 0, 0, 0);

        // Randomized measurements.
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < P_AVG; k++) begin
                int r = $urandom_range(0, 9);
                if (r <= P_CELLS) rp[k] = P_CELLS'((1 << r) - 1);
                else              rp[k] = P_CELLS'($urandom);
            end
            set_pats(rp[0], rp[1], rp[2], rp[3]);
            for (int k = 0; k < P_AVG; k++) begin
                if ($urandom_range(0, 2) == 0) hold[k] = $urandom_range(0, 40);
                hval[k] = P_CELLS'($urandom_range(1, 255));
            end
            run_meas(1, $urandom_range(0, 3), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
